// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and write-back.
//   Non-memory ops are forwarded to write-back one register stage later.
//   Loads and stores move one byte per cycle over an 8-bit RAM port
//   (little-endian, wrapping addresses, misalignment allowed).
//   Upstream is stalled while a multi-cycle access is in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 system ready; low freezes the stage (mem_wr forced 0)
//   ex_valid/ex_op      execute bundle valid and op code
//   ex_rd_data          ALU result, or effective address for loads/stores
//   ex_rd_addr          destination register
//   ex_st_data          store data
//   mem_din             RAM read data (valid the cycle after mem_a is presented)
//   mem_a/mem_dout/mem_wr  RAM address, write data, write enable (registered)
//   stall_req           upstream must hold its bundle (registered)
//   wb_valid/wb_rd_addr/wb_rd_data  write-back pulse, register, value
//
// Op encoding shared with the execute stage (any other value is a non-memory op):
//   LB=0x20 LH=0x21 LW=0x22 LBU=0x24 LHU=0x25 SB=0x28 SH=0x29 SW=0x2A
`timescale 1ns/1ps

module mem_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [DATA_W-1:0] ex_rd_data,
  input  logic [4:0]        ex_rd_addr,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic              stall_req,
  output logic              wb_valid,
  output logic [4:0]        wb_rd_addr,
  output logic [DATA_W-1:0] wb_rd_data
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned BUF_W = 24;

  localparam logic [OP_W-1:0] OP_LB  = OP_W'(6'h20);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(6'h21);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'h22);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(6'h24);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(6'h25);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(6'h28);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(6'h29);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'h2A);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched bundle and access bookkeeping
  logic [OP_W-1:0]   op_q,    op_d;
  logic [REG_W-1:0]  rd_q,    rd_d;
  logic [DATA_W-1:0] st_q,    st_d;
  logic [1:0]        last_q,  last_d;   // byte count minus one
  logic [1:0]        ia_q,    ia_d;     // index of the byte currently on mem_a
  logic [1:0]        ic_q,    ic_d;     // index of the next load byte to capture
  logic              first_q, first_d;  // mem_din not yet valid for this load
  logic [BUF_W-1:0]  byte_q,  byte_d;   // captured load bytes 0..2

  // Next values of the registered outputs
  logic [ADDR_W-1:0] mem_a_d;
  logic [7:0]        mem_dout_d;
  logic              mem_wr_d;
  logic              stall_d;
  logic              wb_valid_d;
  logic [REG_W-1:0]  wb_rd_addr_d;
  logic [DATA_W-1:0] wb_rd_data_d;

  logic              dec_load;
  logic              dec_store;
  logic [1:0]        dec_last;
  logic [31:0]       load_raw;
  logic [DATA_W-1:0] load_ext;
  logic [1:0]        ia_inc;
  logic [7:0]        st_byte;

  // Op decode: memory class and byte count
  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_last  = 2'd0;
    case (ex_op)
      OP_LB, OP_LBU: begin dec_load  = 1'b1; dec_last = 2'd0; end
      OP_LH, OP_LHU: begin dec_load  = 1'b1; dec_last = 2'd1; end
      OP_LW:         begin dec_load  = 1'b1; dec_last = 2'd3; end
      OP_SB:         begin dec_store = 1'b1; dec_last = 2'd0; end
      OP_SH:         begin dec_store = 1'b1; dec_last = 2'd1; end
      OP_SW:         begin dec_store = 1'b1; dec_last = 2'd3; end
      default:       ;
    endcase
  end

  // Load result: the final byte is taken straight from mem_din on the completing edge
  always_comb begin
    case (last_q)
      2'd0:    load_raw = {24'h0, mem_din};
      2'd1:    load_raw = {16'h0, mem_din, byte_q[7:0]};
      default: load_raw = {mem_din, byte_q};
    endcase
    case (op_q)
      OP_LB:   load_ext = {{(DATA_W-8){load_raw[7]}}, load_raw[7:0]};
      OP_LH:   load_ext = {{(DATA_W-16){load_raw[15]}}, load_raw[15:0]};
      default: load_ext = DATA_W'(load_raw);
    endcase
  end

  // Next store byte lane
  assign ia_inc  = ia_q + 2'd1;
  assign st_byte = 8'(st_q >> {ia_inc, 3'b000});

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rdy low holds the state
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (ex_valid && dec_load) begin
            state_d = S_LOAD;
          end else if (ex_valid && dec_store) begin
            state_d = S_STORE;
          end
        end
        S_LOAD: begin
          if (!first_q && (ic_q == last_q)) begin
            state_d = S_IDLE;
          end
        end
        S_STORE: begin
          // Finish only once the last byte was actually written (mem_wr was high)
          if (mem_wr && (ia_q == last_q)) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    mem_a_d      = mem_a;
    mem_dout_d   = mem_dout;
    mem_wr_d     = 1'b0;
    stall_d      = stall_req;
    wb_valid_d   = 1'b0;
    wb_rd_addr_d = wb_rd_addr;
    wb_rd_data_d = wb_rd_data;
    op_d         = op_q;
    rd_d         = rd_q;
    st_d         = st_q;
    last_d       = last_q;
    ia_d         = ia_q;
    ic_d         = ic_q;
    first_d      = first_q;
    byte_d       = byte_q;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (dec_load || dec_store) begin
            mem_a_d = ADDR_W'(ex_rd_data);
            op_d    = ex_op;
            rd_d    = ex_rd_addr;
            last_d  = dec_last;
            ia_d    = 2'd0;
            ic_d    = 2'd0;
            first_d = 1'b1;
            stall_d = 1'b1;
            if (dec_store) begin
              mem_dout_d = ex_st_data[7:0];
              mem_wr_d   = 1'b1;
              st_d       = ex_st_data;
            end
          end else begin
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = ex_rd_addr;
            wb_rd_data_d = ex_rd_data;
          end
        end
      end

      S_LOAD: begin
        // Address issue runs two edges ahead of byte capture
        if (ia_q != last_q) begin
          mem_a_d = mem_a + ADDR_W'(1);
          ia_d    = ia_inc;
        end
        if (first_q) begin
          first_d = 1'b0;
        end else begin
          case (ic_q)
            2'd0:    byte_d[7:0]   = mem_din;
            2'd1:    byte_d[15:8]  = mem_din;
            2'd2:    byte_d[23:16] = mem_din;
            default: ;
          endcase
          if (ic_q == last_q) begin
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = rd_q;
            wb_rd_data_d = load_ext;
            stall_d      = 1'b0;
          end else begin
            ic_d = ic_q + 2'd1;
          end
        end
      end

      S_STORE: begin
        if (!mem_wr) begin
          // Returning from a rdy pause: the held byte was never written, present it again
          mem_wr_d = 1'b1;
        end else if (ia_q == last_q) begin
          wb_valid_d   = 1'b1;
          wb_rd_addr_d = '0;
          wb_rd_data_d = '0;
          stall_d      = 1'b0;
        end else begin
          ia_d       = ia_inc;
          mem_a_d    = mem_a + ADDR_W'(1);
          mem_dout_d = st_byte;
          mem_wr_d   = 1'b1;
        end
      end

      default: ;
    endcase
  end

  // Datapath and output registers; rdy low holds everything but mem_wr
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      stall_req  <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd_addr <= '0;
      wb_rd_data <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      st_q       <= '0;
      last_q     <= '0;
      ia_q       <= '0;
      ic_q       <= '0;
      first_q    <= 1'b0;
      byte_q     <= '0;
    end else if (rdy) begin
      mem_a      <= mem_a_d;
      mem_dout   <= mem_dout_d;
      mem_wr     <= mem_wr_d;
      stall_req  <= stall_d;
      wb_valid   <= wb_valid_d;
      wb_rd_addr <= wb_rd_addr_d;
      wb_rd_data <= wb_rd_data_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      st_q       <= st_d;
      last_q     <= last_d;
      ia_q       <= ia_d;
      ic_q       <= ic_d;
      first_q    <= first_d;
      byte_q     <= byte_d;
    end else begin
      mem_wr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage.
//   Stimulus pushes expected write-back pulses and RAM writes (with the cycle
//   they must occur in) into queues; a negedge monitor pops and compares.
//   A byte RAM model, paused by rdy like the real system RAM, serves the DUT.
`timescale 1ns/1ps

module tb_mem_stage;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_UNK = 6'h3F;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h22;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        ex_valid = 1'b0;
  logic [5:0]  ex_op = '0;
  logic [31:0] ex_rd_data = '0;
  logic [4:0]  ex_rd_addr = '0;
  logic [31:0] ex_st_data = '0;
  logic [7:0]  mem_din = '0;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        stall_req;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_rd_data (ex_rd_data),
    .ex_rd_addr (ex_rd_addr),
    .ex_st_data (ex_st_data),
    .mem_din    (mem_din),
    .mem_a      (mem_a),
    .mem_dout   (mem_dout),
    .mem_wr     (mem_wr),
    .stall_req  (stall_req),
    .wb_valid   (wb_valid),
    .wb_rd_addr (wb_rd_addr),
    .wb_rd_data (wb_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wb_exp_t;
  typedef struct { int cyc; logic [31:0] a; logic [7:0] d; } wr_exp_t;

  wb_exp_t exp_wb[$];
  wr_exp_t exp_wr[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;      // cycle N runs from edge N to edge N+1
  logic rdy_prev = 1'b1;
  logic mon_en = 1'b0;
  logic [7:0] ram [1024];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdy_prev <= rdy;
  end

  // Synchronous byte RAM, paused while rdy is low
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
      mem_din <= ram[mem_a[9:0]];
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    wb_exp_t ew;
    wr_exp_t er;
    if (mon_en) begin
      if (wb_valid && rdy) begin
        n_cmp++;
        if (exp_wb.size() == 0) begin
          n_bad++;
          $display("FAIL wb_unexpected: cyc=%0d rd=%0d data=%h, expected no write-back", cyc, wb_rd_addr, wb_rd_data);
        end else begin
          ew = exp_wb.pop_front();
          if (cyc != ew.cyc || wb_rd_addr !== ew.rd || wb_rd_data !== ew.data) begin
            n_bad++;
            $display("FAIL wb: got cyc=%0d rd=%0d data=%h, expected cyc=%0d rd=%0d data=%h",
                     cyc, wb_rd_addr, wb_rd_data, ew.cyc, ew.rd, ew.data);
          end
        end
      end
      if (mem_wr && rdy) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_bad++;
          $display("FAIL wr_unexpected: cyc=%0d a=%h d=%h, expected no RAM write", cyc, mem_a, mem_dout);
        end else begin
          er = exp_wr.pop_front();
          if (cyc != er.cyc || mem_a !== er.a || mem_dout !== er.d) begin
            n_bad++;
            $display("FAIL wr: got cyc=%0d a=%h d=%h, expected cyc=%0d a=%h d=%h",
                     cyc, mem_a, mem_dout, er.cyc, er.a, er.d);
          end
        end
      end
      if (!rdy_prev) begin
        n_cmp++;
        if (mem_wr !== 1'b0) begin
          n_bad++;
          $display("FAIL wr_while_paused: cyc=%0d mem_wr=%b, expected 0", cyc, mem_wr);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_wb(input int c, input logic [4:0] rd, input logic [31:0] d);
    wb_exp_t e;
    e.cyc = c; e.rd = rd; e.data = d;
    exp_wb.push_back(e);
  endtask

  task automatic push_wr(input int c, input logic [31:0] a, input logic [7:0] d);
    wr_exp_t e;
    e.cyc = c; e.a = a; e.d = d;
    exp_wr.push_back(e);
  endtask

  // Present a bundle for exactly one edge; acc is the accept edge / cycle 0
  task automatic send(input logic [5:0] op, input logic [31:0] d, input logic [4:0] rd,
                      input logic [31:0] st, output int acc);
    ex_valid = 1'b1; ex_op = op; ex_rd_data = d; ex_rd_addr = rd; ex_st_data = st;
    acc = cyc + 1;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
    ram[10'h200] = 8'h80;
    ram[10'h210] = 8'h34; ram[10'h211] = 8'hF2;
    ram[10'h300] = 8'h11; ram[10'h301] = 8'h22; ram[10'h302] = 8'h33; ram[10'h303] = 8'h44;

    // Reset state
    tick(3);
    rst = 1'b0;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_stall", {31'h0, stall_req}, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_wb_rd_addr", {27'h0, wb_rd_addr}, 32'h0);
    chk("rst_wb_rd_data", wb_rd_data, 32'h0);
    mon_en = 1'b1;

    // ALU forwarding, then three back-to-back ops
    send(OP_ADD, 32'h12345678, 5'd5, 32'h0, acc);
    push_wb(acc, 5'd5, 32'h12345678);
    chk("alu_stall", {31'h0, stall_req}, 32'h0);
    send(OP_SUB, 32'hA5A5_0001, 5'd6, 32'h0, acc);
    push_wb(acc, 5'd6, 32'hA5A5_0001);
    send(OP_UNK, 32'h0000_0002, 5'd7, 32'hFFFF_FFFF, acc);
    push_wb(acc, 5'd7, 32'h0000_0002);
    chk("unk_no_wr", {31'h0, mem_wr}, 32'h0);
    send(OP_ADD, 32'hFFFF_FFFF, 5'd31, 32'h0, acc);
    push_wb(acc, 5'd31, 32'hFFFF_FFFF);
    chk("alu_stall_b2b", {31'h0, stall_req}, 32'h0);
    tick(1);

    // LW at 0x100: addresses, stall window, wb in cycle 5
    send(OP_LW, 32'h100, 5'd8, 32'h0, acc);
    push_wb(acc + 5, 5'd8, 32'h12345678);
    for (int k = 0; k <= 5; k++) begin
      if (k < 4) chk($sformatf("lw_mem_a_c%0d", k), mem_a, 32'h100 + 32'(k));
      chk($sformatf("lw_stall_c%0d", k), {31'h0, stall_req}, (k < 5) ? 32'd1 : 32'd0);
      if (k < 5) tick(1);
    end

    // Sign/zero extension; each accepted at the edge ending the previous wb cycle
    send(OP_LB, 32'h200, 5'd1, 32'h0, acc);
    push_wb(acc + 2, 5'd1, 32'hFFFFFF80);
    tick(2);
    send(OP_LBU, 32'h200, 5'd2, 32'h0, acc);
    push_wb(acc + 2, 5'd2, 32'h00000080);
    tick(2);
    send(OP_LH, 32'h210, 5'd3, 32'h0, acc);
    push_wb(acc + 3, 5'd3, 32'hFFFFF234);
    tick(3);
    send(OP_LHU, 32'h210, 5'd4, 32'h0, acc);
    push_wb(acc + 3, 5'd4, 32'h0000F234);
    tick(3);

    // SW across the address wrap, then read it back with LW
    send(OP_SW, 32'hFFFF_FFFE, 5'd9, 32'hDEADBEEF, acc);
    push_wr(acc,     32'hFFFF_FFFE, 8'hEF);
    push_wr(acc + 1, 32'hFFFF_FFFF, 8'hBE);
    push_wr(acc + 2, 32'h0000_0000, 8'hAD);
    push_wr(acc + 3, 32'h0000_0001, 8'hDE);
    push_wb(acc + 4, 5'd0, 32'h0);
    tick(4);
    chk("sw_stall_wb_cycle", {31'h0, stall_req}, 32'h0);
    send(OP_LW, 32'hFFFF_FFFE, 5'd10, 32'h0, acc);
    push_wb(acc + 5, 5'd10, 32'hDEADBEEF);
    tick(6);

    // LW with rdy low in cycles 2..4: resumes, wb in cycle 8
    send(OP_LW, 32'h300, 5'd11, 32'h0, acc);
    push_wb(acc + 8, 5'd11, 32'h44332211);
    tick(2);
    rdy = 1'b0;
    tick(3);
    chk("lw_pause_mem_a", mem_a, 32'h302);
    chk("lw_pause_stall", {31'h0, stall_req}, 32'h1);
    rdy = 1'b1;
    tick(3);

    // SH with rdy low right after accept: held byte is written again on resume
    send(OP_SH, 32'h080, 5'd12, 32'hAABBCCDD, acc);
    rdy = 1'b0;
    push_wr(acc + 3, 32'h080, 8'hDD);
    push_wr(acc + 4, 32'h081, 8'hCC);
    push_wb(acc + 5, 5'd0, 32'h0);
    tick(2);
    rdy = 1'b1;
    tick(4);
    send(OP_LHU, 32'h080, 5'd13, 32'h0, acc);
    push_wb(acc + 3, 5'd13, 32'h0000CCDD);
    tick(4);

    // SW aborted by reset at edge 2: only two bytes land, no wb
    send(OP_SW, 32'h040, 5'd14, 32'h01020304, acc);
    push_wr(acc,     32'h040, 8'h04);
    push_wr(acc + 1, 32'h041, 8'h03);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("abort_stall", {31'h0, stall_req}, 32'h0);
    chk("abort_mem_a", mem_a, 32'h0);
    chk("abort_wb_valid", {31'h0, wb_valid}, 32'h0);
    send(OP_ADD, 32'hCAFEF00D, 5'd15, 32'h0, acc);
    push_wb(acc, 5'd15, 32'hCAFEF00D);
    send(OP_LW, 32'h040, 5'd16, 32'h0, acc);
    push_wb(acc + 5, 5'd16, 32'h00000304);
    tick(8);

    chk("wb_queue_drained", 32'(exp_wb.size()), 32'h0);
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
